// File: rtl/mmu_bridge_pkg.sv
// Shared types and constants for the MMU-to-AXI RAM bridge.
// Optional feature macro: ADDR_RANGE_CHECK_EN (see axi_ram_slave).
package mmu_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StResp,
    StDone,
    StWaitFree
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam logic [31:0] DefaultBaseAddr = 32'hC000_0000;
  // log2 of the 32-byte word size
  localparam int unsigned WordOff = 5;

endpackage

// File: rtl/mmu_bridge_axi_ram_slave.sv
// Single-beat AXI4 slave with a Depth x DataW RAM; all readies tied high.
// With ADDR_RANGE_CHECK_EN defined, out-of-range accesses answer SLVERR and touch nothing.
module axi_ram_slave
  import mmu_bridge_pkg::*;
#(
  parameter int unsigned      AddrW    = 32,
  parameter int unsigned      DataW    = 256,
  parameter logic [AddrW-1:0] BaseAddr = DefaultBaseAddr,
  parameter int unsigned      Depth    = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AddrW-1:0]   aw_addr,
  input  logic               aw_valid,
  output logic               aw_ready,
  input  logic [DataW-1:0]   w_data,
  input  logic [DataW/8-1:0] w_strb,
  input  logic               w_valid,
  output logic               w_ready,
  output logic [1:0]         b_resp,
  output logic               b_valid,
  input  logic               b_ready,
  input  logic [AddrW-1:0]   ar_addr,
  input  logic               ar_valid,
  output logic               ar_ready,
  output logic [DataW-1:0]   r_data,
  output logic [1:0]         r_resp,
  output logic               r_valid,
  input  logic               r_ready
);

  localparam int unsigned IdxW  = $clog2(Depth);
  localparam int unsigned StrbW = DataW / 8;

  logic [DataW-1:0] mem [Depth];

  logic            wr_fire, rd_fire;
  logic            wr_ok, rd_ok;
  logic [IdxW-1:0] wr_idx, rd_idx;

  assign aw_ready = 1'b1;
  assign w_ready  = 1'b1;
  assign ar_ready = 1'b1;

  assign wr_fire = aw_valid & w_valid;
  assign rd_fire = ar_valid;

`ifdef ADDR_RANGE_CHECK_EN
  localparam logic [AddrW:0] Lo = (AddrW + 1)'(BaseAddr);
  localparam logic [AddrW:0] Hi = Lo + ((AddrW + 1)'(Depth) << WordOff);

  assign wr_ok  = ({1'b0, aw_addr} >= Lo) && ({1'b0, aw_addr} < Hi);
  assign rd_ok  = ({1'b0, ar_addr} >= Lo) && ({1'b0, ar_addr} < Hi);
  assign wr_idx = IdxW'((aw_addr - BaseAddr) >> WordOff);
  assign rd_idx = IdxW'((ar_addr - BaseAddr) >> WordOff);
`else
  // No decode beyond the index bits: addresses alias modulo Depth
  assign wr_ok  = 1'b1;
  assign rd_ok  = 1'b1;
  assign wr_idx = IdxW'(aw_addr >> WordOff);
  assign rd_idx = IdxW'(ar_addr >> WordOff);
`endif

  // RAM contents are deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (wr_fire && wr_ok) begin
      for (int b = 0; b < StrbW; b++) begin
        if (w_strb[b]) mem[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_resp  <= RespOkay;
      r_valid <= 1'b0;
      r_resp  <= RespOkay;
      r_data  <= '0;
    end else begin
      if (wr_fire) begin
        b_valid <= 1'b1;
        b_resp  <= wr_ok ? RespOkay : RespSlvErr;
      end else if (b_ready) begin
        b_valid <= 1'b0;
      end
      if (rd_fire) begin
        r_valid <= 1'b1;
        r_resp  <= rd_ok ? RespOkay : RespSlvErr;
        r_data  <= rd_ok ? mem[rd_idx] : '0;
      end else if (r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mmu_bridge_top.sv
// Pulse-handshake MMU port bridged to one AXI transaction against an on-chip RAM.
// Optional feature macro ADDR_RANGE_CHECK_EN is handled inside axi_ram_slave.
module mmu_bridge_top
  import mmu_bridge_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DefaultBaseAddr,
  parameter int unsigned       DEPTH     = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              rst,
  input  logic              i_driveFMMU,
  output logic              o_free2MMU,
  output logic              o_drive2MMU,
  input  logic              i_freeFromMMU,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic rst_n;
  assign rst_n = ARESETN & rst;

  state_e            state_q, state_d;
  logic              drive_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              capture;

  logic              aw_valid, aw_ready, w_valid, w_ready;
  logic              b_valid, b_ready, ar_valid, ar_ready;
  logic              r_valid, r_ready;
  logic [1:0]        b_resp, r_resp, resp_sel;
  logic [DATA_W-1:0] r_data;

  assign capture = (state_q == StIdle) && i_driveFMMU && !drive_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (capture) state_d = StAddr;
      StAddr:     if (wen_q ? (aw_ready && w_ready) : ar_ready) state_d = StResp;
      StResp:     if (wen_q ? b_valid : r_valid) state_d = StDone;
      StDone:     state_d = i_freeFromMMU ? StIdle : StWaitFree;
      StWaitFree: if (i_freeFromMMU) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // A failed response never exposes slave data on rdata
  assign resp_sel = wen_q ? b_resp : r_resp;

  always_comb begin
    rdata_d = rdata_q;
    if (state_q == StResp && !wen_q && r_valid) begin
      rdata_d = (resp_sel == RespOkay) ? r_data : '0;
    end
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      drive_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      drive_q <= i_driveFMMU;
      rdata_q <= rdata_d;
      if (capture) begin
        wen_q   <= wen;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  assign aw_valid = (state_q == StAddr) && wen_q;
  assign w_valid  = (state_q == StAddr) && wen_q;
  assign ar_valid = (state_q == StAddr) && !wen_q;
  assign b_ready  = (state_q == StResp) && wen_q;
  assign r_ready  = (state_q == StResp) && !wen_q;

  assign o_free2MMU  = (state_q == StAddr);
  assign o_drive2MMU = (state_q == StDone);
  assign rdata       = rdata_q;

  axi_ram_slave #(
    .AddrW    (ADDR_W),
    .DataW    (DATA_W),
    .BaseAddr (BASE_ADDR),
    .Depth    (DEPTH)
  ) u_ram (
    .clk      (ACLK),
    .rst_n    (rst_n),
    .aw_addr  (addr_q),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .w_data   (wdata_q),
    .w_strb   ({(DATA_W / 8){1'b1}}),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .b_resp   (b_resp),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .ar_addr  (addr_q),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .r_data   (r_data),
    .r_resp   (r_resp),
    .r_valid  (r_valid),
    .r_ready  (r_ready)
  );

endmodule

// File: tb/tb_mmu_bridge_top.sv
// Scoreboard bench for mmu_bridge_top: requests push expectations, a monitor checks output pulses.
module tb_mmu_bridge_top;
  import mmu_bridge_pkg::*;

  localparam logic [255:0] PatA =
    256'hDEAD_BEEF_CAFE_BABE_1122_3344_5566_7788_99AA_BBCC_DDEE_FF00_1234_5678_9ABC_DEF0;
  localparam logic [255:0] PatB =
    256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [255:0] PatC = {8{32'hA5A5_5A5A}};

  logic         ACLK = 1'b0;
  logic         ARESETN, rst;
  logic         i_driveFMMU, i_freeFromMMU, wen;
  logic         o_free2MMU, o_drive2MMU;
  logic [31:0]  addr;
  logic [255:0] wdata, rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_free = 0;

  int           free_q[$];
  logic [255:0] exp_q[$];

  mmu_bridge_top dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .rst           (rst),
    .i_driveFMMU   (i_driveFMMU),
    .o_free2MMU    (o_free2MMU),
    .o_drive2MMU   (o_drive2MMU),
    .i_freeFromMMU (i_freeFromMMU),
    .wen           (wen),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (o_free2MMU) begin
      if (free_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL free_unexpected: got pulse at cycle %0d want none", cyc);
      end else begin
        chk("free_cycle", 256'(cyc), 256'(free_q.pop_front()));
      end
      last_free = cyc;
    end
    if (o_drive2MMU) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL drive_unexpected: got pulse at cycle %0d want none", cyc);
      end else begin
        chk("drive_latency", 256'(cyc), 256'(last_free + 2));
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge ACLK);
      chk("idle_free", 256'(o_free2MMU), 256'(0));
      chk("idle_drive", 256'(o_drive2MMU), 256'(0));
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (o_drive2MMU) seen = 1'b1;
      else @(negedge ACLK);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL drive_timeout: got no pulse want pulse within 20 cycles");
    end
  endtask

  task automatic ack();
    i_freeFromMMU = 1'b1;
    @(negedge ACLK);
    i_freeFromMMU = 1'b0;
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d,
                     input logic [255:0] exp, input bit do_ack);
    @(negedge ACLK);
    wen = w;
    addr = a;
    wdata = d;
    i_driveFMMU = 1'b1;
    free_q.push_back(cyc + 1);
    exp_q.push_back(exp);
    @(negedge ACLK);
    i_driveFMMU = 1'b0;
    wait_done();
    if (do_ack) ack();
  endtask

  initial begin
    ARESETN = 1'b0;
    rst = 1'b0;
    i_driveFMMU = 1'b0;
    i_freeFromMMU = 1'b0;
    wen = 1'b0;
    addr = '0;
    wdata = '0;

    // 1) long reset, then quiet idle
    repeat (100) @(negedge ACLK);
    chk("rst_free", 256'(o_free2MMU), 256'(0));
    chk("rst_drive", 256'(o_drive2MMU), 256'(0));
    chk("rst_rdata", rdata, 256'(0));
    ARESETN = 1'b1;
    rst = 1'b1;
    @(negedge ACLK);
    chk("rst_state", 256'(dut.state_q), 256'(StIdle));
    idle_check(5);

    // 2) write leaves rdata at 0
    req(1'b1, 32'hC000_0000, PatA, 256'(0), 1'b1);
    chk("wr_rdata_hold", rdata, 256'(0));

    // 3) read back
    req(1'b0, 32'hC000_0000, '0, PatA, 1'b1);

    // 4) request before ack is ignored
    req(1'b0, 32'hC000_0000, '0, PatA, 1'b0);
    i_driveFMMU = 1'b1;
    @(negedge ACLK);
    i_driveFMMU = 1'b0;
    idle_check(4);
    ack();
    req(1'b1, 32'hC000_0020, PatB, PatA, 1'b1);

    // 5) level held high for 10 cycles gives one transaction
    @(negedge ACLK);
    wen = 1'b0;
    addr = 32'hC000_0020;
    i_driveFMMU = 1'b1;
    free_q.push_back(cyc + 1);
    exp_q.push_back(PatB);
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      i_freeFromMMU = o_drive2MMU;
    end
    i_driveFMMU = 1'b0;
    i_freeFromMMU = 1'b0;
    idle_check(3);
    chk("held_rdata", rdata, PatB);

    // 5b) ARESETN dropped in RESP
    @(negedge ACLK);
    wen = 1'b1;
    addr = 32'hC000_0040;
    wdata = PatC;
    i_driveFMMU = 1'b1;
    free_q.push_back(cyc + 1);
    @(negedge ACLK);
    i_driveFMMU = 1'b0;
    @(negedge ACLK);
    chk("in_resp", 256'(dut.state_q), 256'(StResp));
    ARESETN = 1'b0;
    #1;
    chk("abort_free", 256'(o_free2MMU), 256'(0));
    chk("abort_drive", 256'(o_drive2MMU), 256'(0));
    chk("abort_rdata", rdata, 256'(0));
    @(negedge ACLK);
    ARESETN = 1'b1;
    idle_check(2);
    req(1'b0, 32'hC000_0020, '0, PatB, 1'b1);
    req(1'b0, 32'hC000_0000, '0, PatA, 1'b1);

    // auxiliary reset also clears rdata
    @(negedge ACLK);
    rst = 1'b0;
    #1;
    chk("aux_rst_rdata", rdata, 256'(0));
    @(negedge ACLK);
    rst = 1'b1;

    // 6) one past the last word
`ifdef ADDR_RANGE_CHECK_EN
    req(1'b0, 32'hC000_8000, '0, 256'(0), 1'b1);
`else
    req(1'b0, 32'hC000_8000, '0, PatA, 1'b1);
`endif

    idle_check(3);
    chk("free_q_empty", 256'(free_q.size()), 256'(0));
    chk("exp_q_empty", 256'(exp_q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
